// File: rtl/counter_share_scheduler.sv
// counter_share_scheduler: round-robin arbiter that lends one up-counter to NUM_REQ requesters,
// running each granted owner for (len+1) enabled ticks and pulsing done or abort back to it.
module counter_share_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_len,
    input  logic                     tick_en,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [CNT_W-1:0]         count,
    output logic [NUM_REQ-1:0]       done,
    output logic                     abort
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [IW-1:0]    last, win;
    logic [CNT_W-1:0] len_q, len_sel;

    // Scan offsets from farthest to nearest so the nearest requester after last wins.
    always_comb begin
        win = last;
        for (int k = NUM_REQ; k >= 1; k--)
            if (req[(int'(last) + k) % NUM_REQ]) win = IW'((int'(last) + k) % NUM_REQ);
        len_sel = req_len[int'(win)*CNT_W +: CNT_W];
    end

    // last doubles as the owner index while a run is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
            count <= '0;
            done  <= '0;
            abort <= 1'b0;
            len_q <= '0;
            last  <= IW'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    done  <= '0;
                    abort <= 1'b0;
                    if (|req) begin
                        grant <= NUM_REQ'(1) << win;
                        busy  <= 1'b1;
                        count <= '0;
                        len_q <= len_sel;
                        last  <= win;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!req[last]) begin
                        abort <= 1'b1;
                        grant <= '0;
                        busy  <= 1'b0;
                        count <= '0;
                        state <= IDLE;
                    end else if (tick_en && count == len_q) begin
                        done  <= grant;
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if (tick_en) begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    done  <= '0;
                    count <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_share_scheduler.sv
// tb_counter_share_scheduler: directed vector table plus hand-written corner sequences
// for the shared-counter round-robin scheduler.
module tb_counter_share_scheduler;
    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_len;
    logic           tick_en;
    logic [N-1:0]   grant;
    logic           busy;
    logic [W-1:0]   count;
    logic [N-1:0]   done;
    logic           abort;

    counter_share_scheduler #(.NUM_REQ(N), .CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .tick_en(tick_en),
        .grant(grant), .busy(busy), .count(count), .done(done), .abort(abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   r;
        logic [N*W-1:0] l;
        logic           t;
        logic [13:0]    e;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nbad = 0;

    function automatic logic [13:0] o(input logic [3:0] g, input logic b, input logic [3:0] c,
                                      input logic [3:0] d, input logic a);
        return {g, b, c, d, a};
    endfunction

    function automatic void add(input logic [3:0] r, input logic [15:0] l, input logic t,
                                input logic [13:0] e);
        vec_t v;
        v.r = r; v.l = l; v.t = t; v.e = e;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [13:0] exp);
        logic [13:0] got;
        got = {grant, busy, count, done, abort};
        nvec++;
        if (got !== exp || (|done && abort)) begin
            nbad++;
            $display("FAIL %s: got grant=%b busy=%b count=%0d done=%b abort=%b, want grant=%b busy=%b count=%0d done=%b abort=%b",
                     nm, got[13:10], got[9], got[8:5], got[4:1], got[0],
                     exp[13:10], exp[9], exp[8:5], exp[4:1], exp[0]);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [15:0] l, input logic t);
        req = r; req_len = l; tick_en = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Round-robin from reset: all four pending, zero lengths.
        for (int k = 0; k < 5; k++) begin
            add(4'b1111, 16'h0000, 1'b1, o(4'b0001 << (k % 4), 1'b1, 4'd0, 4'b0000, 1'b0));
            add(4'b1111, 16'h0000, 1'b1, o(4'b0000, 1'b0, 4'd0, 4'b0001 << (k % 4), 1'b0));
            add(4'b1111, 16'h0000, 1'b1, o(4'b0000, 1'b0, 4'd0, 4'b0000, 1'b0));
        end
        add(4'b0000, 16'h0000, 1'b1, o(4'b0000, 1'b0, 4'd0, 4'b0000, 1'b0));
        // Single run, len0=3.
        add(4'b0001, 16'h0003, 1'b1, o(4'b0001, 1'b1, 4'd0, 4'b0000, 1'b0));
        add(4'b0001, 16'h0003, 1'b1, o(4'b0001, 1'b1, 4'd1, 4'b0000, 1'b0));
        add(4'b0001, 16'h0003, 1'b1, o(4'b0001, 1'b1, 4'd2, 4'b0000, 1'b0));
        add(4'b0001, 16'h0003, 1'b1, o(4'b0001, 1'b1, 4'd3, 4'b0000, 1'b0));
        add(4'b0001, 16'h0003, 1'b1, o(4'b0000, 1'b0, 4'd3, 4'b0001, 1'b0));
        add(4'b0000, 16'h0003, 1'b1, o(4'b0000, 1'b0, 4'd0, 4'b0000, 1'b0));
        add(4'b0000, 16'h0003, 1'b1, o(4'b0000, 1'b0, 4'd0, 4'b0000, 1'b0));

        req = 4'b1111; req_len = '0; tick_en = 1'b1; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("reset_hold", o(4'b0000, 1'b0, 4'd0, 4'b0000, 1'b0));
        @(negedge clk) rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].l, tbl[i].t);
            chk($sformatf("vec%0d", i), tbl[i].e);
        end

        // Max length with alternating tick_en; req_len dropped after grant must not matter.
        step(4'b0100, 16'h0F00, 1'b0);
        chk("max_grant", o(4'b0100, 1'b1, 4'd0, 4'b0000, 1'b0));
        for (int i = 0; i <= 30; i++) begin
            step(4'b0100, 16'h0000, (i % 2) == 0);
            if (i < 30) chk($sformatf("max_cnt%0d", i), o(4'b0100, 1'b1, 4'(i / 2 + 1), 4'b0000, 1'b0));
            else        chk("max_done", o(4'b0000, 1'b0, 4'd15, 4'b0100, 1'b0));
        end
        step(4'b0000, 16'h0000, 1'b0);
        chk("max_after", o(4'b0000, 1'b0, 4'd0, 4'b0000, 1'b0));

        // Abort of owner 1 at count 2, pending requester 3 served next.
        step(4'b0010, 16'h00A0, 1'b1);
        chk("ab_grant", o(4'b0010, 1'b1, 4'd0, 4'b0000, 1'b0));
        step(4'b1010, 16'h00A0, 1'b1);
        chk("ab_c1", o(4'b0010, 1'b1, 4'd1, 4'b0000, 1'b0));
        step(4'b1010, 16'h00A0, 1'b1);
        chk("ab_c2", o(4'b0010, 1'b1, 4'd2, 4'b0000, 1'b0));
        step(4'b1000, 16'h00A0, 1'b1);
        chk("ab_pulse", o(4'b0000, 1'b0, 4'd0, 4'b0000, 1'b1));
        step(4'b1000, 16'h0000, 1'b1);
        chk("ab_next", o(4'b1000, 1'b1, 4'd0, 4'b0000, 1'b0));
        step(4'b1000, 16'h0000, 1'b1);
        chk("ab_done3", o(4'b0000, 1'b0, 4'd0, 4'b1000, 1'b0));
        step(4'b0000, 16'h0000, 1'b1);
        chk("ab_idle", o(4'b0000, 1'b0, 4'd0, 4'b0000, 1'b0));

        // Asynchronous reset mid-run, then pointer restarts at requester 0.
        step(4'b0100, 16'h0900, 1'b1);
        chk("rr_grant", o(4'b0100, 1'b1, 4'd0, 4'b0000, 1'b0));
        for (int i = 1; i <= 5; i++) step(4'b0100, 16'h0900, 1'b1);
        chk("rr_c5", o(4'b0100, 1'b1, 4'd5, 4'b0000, 1'b0));
        #1 rst_n = 1'b0;
        #1 chk("rr_async", o(4'b0000, 1'b0, 4'd0, 4'b0000, 1'b0));
        req = 4'b0110;
        @(posedge clk);
        #1 chk("rr_held", o(4'b0000, 1'b0, 4'd0, 4'b0000, 1'b0));
        @(negedge clk) rst_n = 1'b1;
        step(4'b0110, 16'h0000, 1'b1);
        chk("rr_ptr", o(4'b0010, 1'b1, 4'd0, 4'b0000, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
